// File: rtl/updown_count_monitor_pkg.sv
// Shared types for the up/down counter observer.
// Tracker states and the delta classes of successive samples.
package updown_count_monitor_pkg;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_UP    = 2'd1,
      S_DOWN  = 2'd2,
      S_STILL = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      D_HOLD = 2'd0,
      D_INC  = 2'd1,
      D_DEC  = 2'd2,
      D_JUMP = 2'd3
   } delta_t;

endpackage

// File: rtl/updown_delta_classify.sv
// Classifies the modular step between the previous and current samples.
// Also flags the two wrap-around steps.
module updown_delta_classify
   import updown_count_monitor_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] prev,
   input  logic [WIDTH-1:0] count_in,
   output delta_t           cls,
   output logic             wrap_up,
   output logic             wrap_dn
);

   localparam logic [WIDTH-1:0] MAX = '1;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] delta;

   always_comb begin
      delta   = count_in - prev;
      cls     = D_JUMP;
      wrap_up = 1'b0;
      wrap_dn = 1'b0;
      if (delta == '0) begin
         cls = D_HOLD;
      end else if (delta == ONE) begin
         cls     = D_INC;
         wrap_up = (prev == MAX);
      end else if (delta == MAX) begin
         cls     = D_DEC;
         wrap_dn = (prev == '0);
      end
   end

endmodule

// File: rtl/updown_count_monitor.sv
// Observer for an up/down counter bus: recovers direction, wraps,
// reversals and illegal jumps, with net-wrap and error counters.
module updown_count_monitor
   import updown_count_monitor_pkg::*;
#(
   parameter int WIDTH  = 3,
   parameter int WRAP_W = 8,
   parameter int ERR_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              resync,
   input  logic [WIDTH-1:0]  count_in,
   output logic              dir_up,
   output logic              dir_known,
   output logic              step_up,
   output logic              step_dn,
   output logic              wrap_up,
   output logic              wrap_dn,
   output logic              reversal,
   output logic              jump_err,
   output logic [WRAP_W-1:0] net_wraps,
   output logic [ERR_W-1:0]  err_count
);

   state_t            state, state_nxt;
   logic [WIDTH-1:0]  prev, prev_nxt;
   logic              dir_up_nxt, dir_known_nxt;
   logic              step_up_nxt, step_dn_nxt;
   logic              wrap_up_nxt, wrap_dn_nxt;
   logic              reversal_nxt, jump_err_nxt;
   logic [WRAP_W-1:0] net_nxt;
   logic [ERR_W-1:0]  err_nxt;

   delta_t cls;
   logic   cls_wu, cls_wd;

   updown_delta_classify #(.WIDTH(WIDTH)) u_classify (
      .prev     (prev),
      .count_in (count_in),
      .cls      (cls),
      .wrap_up  (cls_wu),
      .wrap_dn  (cls_wd)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_EMPTY;
         prev      <= '0;
         dir_up    <= 1'b0;
         dir_known <= 1'b0;
         step_up   <= 1'b0;
         step_dn   <= 1'b0;
         wrap_up   <= 1'b0;
         wrap_dn   <= 1'b0;
         reversal  <= 1'b0;
         jump_err  <= 1'b0;
         net_wraps <= '0;
         err_count <= '0;
      end else begin
         state     <= state_nxt;
         prev      <= prev_nxt;
         dir_up    <= dir_up_nxt;
         dir_known <= dir_known_nxt;
         step_up   <= step_up_nxt;
         step_dn   <= step_dn_nxt;
         wrap_up   <= wrap_up_nxt;
         wrap_dn   <= wrap_dn_nxt;
         reversal  <= reversal_nxt;
         jump_err  <= jump_err_nxt;
         net_wraps <= net_nxt;
         err_count <= err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      prev_nxt      = prev;
      dir_up_nxt    = dir_up;
      dir_known_nxt = dir_known;
      step_up_nxt   = 1'b0;
      step_dn_nxt   = 1'b0;
      wrap_up_nxt   = 1'b0;
      wrap_dn_nxt   = 1'b0;
      reversal_nxt  = 1'b0;
      jump_err_nxt  = 1'b0;
      net_nxt       = net_wraps;
      err_nxt       = err_count;

      // resync drops the baseline but keeps the accumulated counters
      if (resync) begin
         state_nxt     = S_EMPTY;
         dir_known_nxt = 1'b0;
      end else if (in_valid) begin
         prev_nxt = count_in;
         if (state == S_EMPTY) begin
            state_nxt = S_STILL;
         end else begin
            case (cls)
               D_INC: begin
                  step_up_nxt   = 1'b1;
                  reversal_nxt  = (state == S_DOWN);
                  state_nxt     = S_UP;
                  dir_up_nxt    = 1'b1;
                  dir_known_nxt = 1'b1;
                  if (cls_wu) begin
                     wrap_up_nxt = 1'b1;
                     net_nxt     = net_wraps + WRAP_W'(1);
                  end
               end
               D_DEC: begin
                  step_dn_nxt   = 1'b1;
                  reversal_nxt  = (state == S_UP);
                  state_nxt     = S_DOWN;
                  dir_up_nxt    = 1'b0;
                  dir_known_nxt = 1'b1;
                  if (cls_wd) begin
                     wrap_dn_nxt = 1'b1;
                     net_nxt     = net_wraps - WRAP_W'(1);
                  end
               end
               D_JUMP: begin
                  jump_err_nxt  = 1'b1;
                  state_nxt     = S_STILL;
                  dir_known_nxt = 1'b0;
                  if (err_count != '1)
                     err_nxt = err_count + ERR_W'(1);
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_updown_count_monitor.sv
// Directed self-checking bench for updown_count_monitor.
// Pulse vector order: step_up step_dn wrap_up wrap_dn reversal jump_err.
module tb_updown_count_monitor;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       in_valid = 1'b0;
   logic       resync = 1'b0;
   logic [2:0] count_in = '0;
   logic       dir_up, dir_known;
   logic       step_up, step_dn, wrap_up, wrap_dn, reversal, jump_err;
   logic [7:0] net_wraps;
   logic [3:0] err_count;
   logic [5:0] pv;

   int total = 0;
   int bad = 0;

   assign pv = {step_up, step_dn, wrap_up, wrap_dn, reversal, jump_err};

   always #5 clk = ~clk;

   updown_count_monitor dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .resync    (resync),
      .count_in  (count_in),
      .dir_up    (dir_up),
      .dir_known (dir_known),
      .step_up   (step_up),
      .step_dn   (step_dn),
      .wrap_up   (wrap_up),
      .wrap_dn   (wrap_dn),
      .reversal  (reversal),
      .jump_err  (jump_err),
      .net_wraps (net_wraps),
      .err_count (err_count)
   );

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      in_valid = 1'b0;
      resync = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic smp(input logic v, input logic [2:0] c, input logic rs);
      in_valid = v;
      count_in = c;
      resync = rs;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      resync = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      total++;
      if ({pv, dir_up, dir_known, net_wraps, err_count} !== '0) begin
         bad++;
         $display("FAIL reset got pv=%b dir=%b%b net=%h err=%h req all 0",
                  pv, dir_up, dir_known, net_wraps, err_count);
      end
   endtask

   task automatic test_count_up();
      logic [5:0] exp;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         smp(1'b1, 3'(i), 1'b0);
         exp = (i == 0) ? 6'b000000 : (i == 8) ? 6'b101000 : 6'b100000;
         total++;
         if (pv !== exp) begin
            bad++;
            $display("FAIL up_step%0d got=%b req=%b", i, pv, exp);
         end
      end
      total++;
      if ({net_wraps, dir_up, dir_known, err_count} !== {8'h01, 2'b11, 4'h0}) begin
         bad++;
         $display("FAIL up_final got net=%h dir=%b%b err=%h req net=01 dir=11 err=0",
                  net_wraps, dir_up, dir_known, err_count);
      end
      smp(1'b0, 3'd5, 1'b0);
      total++;
      if (pv !== 6'b0) begin
         bad++;
         $display("FAIL up_idle got=%b req=000000", pv);
      end
   endtask

   task automatic test_count_down();
      logic [2:0] vals [6] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};
      logic [5:0] exps [6] = '{6'b000000, 6'b010000, 6'b010000,
                               6'b010000, 6'b010100, 6'b010000};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         smp(1'b1, vals[i], 1'b0);
         total++;
         if (pv !== exps[i]) begin
            bad++;
            $display("FAIL dn_step%0d got=%b req=%b", i, pv, exps[i]);
         end
      end
      total++;
      if ({net_wraps, dir_up, dir_known, err_count} !== {8'hFF, 2'b01, 4'h0}) begin
         bad++;
         $display("FAIL dn_final got net=%h dir=%b%b err=%h req net=ff dir=01 err=0",
                  net_wraps, dir_up, dir_known, err_count);
      end
   endtask

   task automatic test_reversal();
      logic [2:0] vals [5] = '{3'd2, 3'd3, 3'd4, 3'd4, 3'd3};
      logic [5:0] exps [5] = '{6'b000000, 6'b100000, 6'b100000,
                               6'b000000, 6'b010010};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         smp(1'b1, vals[i], 1'b0);
         total++;
         if (pv !== exps[i]) begin
            bad++;
            $display("FAIL rev_step%0d got=%b req=%b", i, pv, exps[i]);
         end
         if (i == 3) begin
            total++;
            if ({dir_up, dir_known} !== 2'b11) begin
               bad++;
               $display("FAIL rev_hold_dir got=%b%b req=11", dir_up, dir_known);
            end
         end
      end
      total++;
      if ({dir_up, dir_known} !== 2'b01) begin
         bad++;
         $display("FAIL rev_dir got=%b%b req=01", dir_up, dir_known);
      end
   endtask

   task automatic test_jump();
      logic [2:0] v;
      logic [3:0] e;
      do_reset();
      smp(1'b1, 3'd1, 1'b0);
      smp(1'b1, 3'd2, 1'b0);
      smp(1'b1, 3'd5, 1'b0);
      total++;
      if ({pv, err_count, dir_known} !== {6'b000001, 4'd1, 1'b0}) begin
         bad++;
         $display("FAIL jump_first got pv=%b err=%h known=%b req 000001 1 0",
                  pv, err_count, dir_known);
      end
      smp(1'b1, 3'd6, 1'b0);
      total++;
      if (pv !== 6'b100000) begin
         bad++;
         $display("FAIL jump_recover got=%b req=100000", pv);
      end
      v = 3'd6;
      for (int k = 1; k <= 17; k++) begin
         v = v + 3'd3;
         smp(1'b1, v, 1'b0);
         e = (k >= 14) ? 4'd15 : 4'(k + 1);
         total++;
         if ({pv, err_count} !== {6'b000001, e}) begin
            bad++;
            $display("FAIL jump_sat%0d got pv=%b err=%0d req 000001 %0d",
                     k, pv, err_count, e);
         end
      end
   endtask

   task automatic test_resync();
      do_reset();
      smp(1'b1, 3'd5, 1'b0);
      smp(1'b1, 3'd6, 1'b0);
      smp(1'b1, 3'd7, 1'b0);
      smp(1'b1, 3'd0, 1'b0);
      smp(1'b1, 3'd0, 1'b1);
      total++;
      if ({pv, dir_known, net_wraps} !== {6'b0, 1'b0, 8'h01}) begin
         bad++;
         $display("FAIL resync_cycle got pv=%b known=%b net=%h req 000000 0 01",
                  pv, dir_known, net_wraps);
      end
      smp(1'b1, 3'd0, 1'b0);
      total++;
      if (pv !== 6'b0) begin
         bad++;
         $display("FAIL resync_base got=%b req=000000", pv);
      end
      smp(1'b1, 3'd1, 1'b0);
      total++;
      if ({pv, net_wraps, err_count} !== {6'b100000, 8'h01, 4'h0}) begin
         bad++;
         $display("FAIL resync_step got pv=%b net=%h err=%h req 100000 01 0",
                  pv, net_wraps, err_count);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      smp(1'b1, 3'd7, 1'b0);
      smp(1'b1, 3'd0, 1'b0);
      smp(1'b1, 3'd3, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      total++;
      if ({pv, dir_up, dir_known, net_wraps, err_count} !== '0) begin
         bad++;
         $display("FAIL async_reset got pv=%b dir=%b%b net=%h err=%h req all 0",
                  pv, dir_up, dir_known, net_wraps, err_count);
      end
      #1;
      reset = 1'b0;
   endtask

   task automatic test_gaps();
      do_reset();
      smp(1'b1, 3'd0, 1'b0);
      smp(1'b0, 3'd4, 1'b0);
      smp(1'b1, 3'd1, 1'b0);
      total++;
      if (pv !== 6'b100000) begin
         bad++;
         $display("FAIL gap_step got=%b req=100000", pv);
      end
      smp(1'b0, 3'd6, 1'b0);
      smp(1'b0, 3'd2, 1'b0);
      total++;
      if ({pv, dir_up, dir_known} !== {6'b0, 2'b11}) begin
         bad++;
         $display("FAIL gap_idle got pv=%b dir=%b%b req 000000 11",
                  pv, dir_up, dir_known);
      end
      smp(1'b1, 3'd0, 1'b0);
      total++;
      if (pv !== 6'b010010) begin
         bad++;
         $display("FAIL gap_rev got=%b req=010010", pv);
      end
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_count_down();
      test_reversal();
      test_jump();
      test_resync();
      test_async_reset();
      test_gaps();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/updown_count_monitor.md
Name: updown_count_monitor

Overview:
Receiving-end observer for the 3-bit up/down counter output bus. It samples the counter value every qualified cycle and recovers several facts from the sequence: step direction, wrap-around events, direction reversals and illegal jumps. It also keeps a signed net-wrap count and a saturating error count. It sits beside the counter in the design and feeds status/debug logic and the verification scoreboard.

Parameters:
WIDTH, 3, width of the observed count bus
WRAP_W, 8, width of the signed net-wrap accumulator (two's complement)
ERR_W, 4, width of the saturating error counter

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  count_in is a valid sample this cycle
resync  input  1  synchronous: discard history; next valid sample becomes the new baseline
count_in  input  WIDTH  counter value being observed
dir_up  output  1  last recovered direction (1=up, 0=down)
dir_known  output  1  dir_up is meaningful
step_up  output  1  one-cycle pulse: +1 step seen
step_dn  output  1  one-cycle pulse: -1 step seen
wrap_up  output  1  one-cycle pulse: max->0 step seen
wrap_dn  output  1  one-cycle pulse: 0->max step seen
reversal  output  1  one-cycle pulse: direction changed vs last step
jump_err  output  1  one-cycle pulse: delta not in {0,+1,-1}
net_wraps  output  WRAP_W  signed wrap_up count minus wrap_dn count
err_count  output  ERR_W  saturating count of jump_err events

Behaviour:
- Reset: all outputs 0; state EMPTY; stored prev value 0.
- States: EMPTY (no baseline), UP, DOWN, STILL (baseline present, no step yet since baseline/error).
- delta = (count_in - prev) mod 2^WIDTH, computed only when in_valid=1.
- EMPTY + valid: prev<=count_in; go to STILL; no pulses.
- UP/DOWN/STILL + valid:
  - delta==1: step_up=1; state UP; dir_up<=1; dir_known<=1.
  - delta==2^WIDTH-1: step_dn=1; state DOWN; dir_up<=0; dir_known<=1.
  - delta==0: no pulses; state, dir_up and dir_known unchanged (hold).
  - otherwise: jump_err=1; err_count+1, saturating at all-ones; state STILL; dir_known<=0.
  - prev<=count_in in every case.
- wrap_up fires together with step_up when prev==2^WIDTH-1 and count_in==0. wrap_dn fires together with step_dn when prev==0 and count_in==2^WIDTH-1.
- net_wraps: +1 on wrap_up, -1 on wrap_dn; wraps modulo 2^WRAP_W without saturation.
- reversal fires only on step_up from DOWN or step_dn from UP. It does not fire from STILL, and a hold (delta==0) between steps does not clear the recorded direction.
- in_valid=0: no state change; all pulses 0.
- Latency: every pulse and status update is registered and appears in the cycle after the sampling edge. Each pulse is exactly one cycle wide.
- resync=1 (priority over in_valid): state<=EMPTY; dir_known<=0; pulses 0; net_wraps and err_count are retained. This is used when the counter is reset mid-operation, so the jump to 0 is not flagged.
- Reset asserted mid-operation: immediate asynchronous clear of everything, including counters.

Decomposition:
- Shared package: state encoding enum (EMPTY, UP, DOWN, STILL) and a delta-classification enum (HOLD, INC, DEC, JUMP).
- Sub-module: updown_delta_classify. Combinational; takes prev, count_in and WIDTH; returns the classification plus wrap_up/wrap_dn flags.
- The top level holds the FSM, registers and counters.

Test Plan:
- Reset then valid samples 0,1,2,...,7,0,1 -> step_up on each step after the first sample; wrap_up once at 7->0; net_wraps=1; dir_up=1; dir_known=1; err_count=0.
- Valid samples 3,2,1,0,7,6 -> step_dn x5; wrap_dn at 0->7; net_wraps=-1 (0xFF); no jump_err.
- Valid samples 2,3,4,4,3 -> step_up x2; hold at 4->4 with no pulses; step_dn plus reversal at 4->3; dir_up=0.
- Valid samples 1,2,5 -> jump_err at 2->5; err_count=1; dir_known=0. Then 6 -> step_up with no reversal. Then 17 consecutive jumps -> err_count saturates at 15.
- Valid samples 5,6, then resync=1, then 0,1 -> no jump_err at 6->0; first pulse is step_up at 0->1; net_wraps unchanged.
- Reset asserted between clock edges mid-sequence -> all outputs 0 immediately, before the next clk edge. in_valid=0 gaps inside a sequence -> no pulses; history is preserved.
